// File: rtl/seg_disp_sched.sv
// Scan controller and frame-boundary arbiter for a shared 8-digit seven-segment display.
// Optional inter-digit blanking is enabled by defining SEG_DISP_BLANK_EN.
module seg_disp_sched #(
  parameter int NUM_DIG    = 8,
  parameter int SCAN_DIV   = 25000,
  parameter int MIN_FRAMES = 4,
  parameter int BLANK_CYC  = 16
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 en,
  input  logic                 req_a,
  input  logic [NUM_DIG*8-1:0] pat_a,
  output logic                 gnt_a,
  input  logic                 req_b,
  input  logic [NUM_DIG*8-1:0] pat_b,
  output logic                 gnt_b,
  output logic [NUM_DIG-1:0]   seg_sel,
  output logic [7:0]           seg_led,
  output logic                 frame_start
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(NUM_DIG);
  localparam int HW = $clog2(MIN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t               r_state;
  logic [SW-1:0]        r_scan_cnt;
  logic [DW-1:0]        r_dig_idx;
  logic                 r_rr_ptr;
  logic [HW-1:0]        r_hold_cnt;
  logic [NUM_DIG*8-1:0] r_snap;
  logic                 r_frame_start;

  logic          w_tick;
  logic          w_fb;
  logic          w_own_req;
  logic          w_oth_req;
  logic          w_win_b;
  logic [HW:0]   w_hold_p1;
  logic          w_hold_ok;
  logic [HW-1:0] w_hold_sat;
  logic [DW-1:0] w_dig_nxt;
  logic          w_blank;
  logic          w_show;
  logic [NUM_DIG-1:0] w_onehot;

  assign w_tick    = en && (r_state != IDLE) &&
                     (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_fb      = w_tick && (r_dig_idx == DW'(NUM_DIG - 1));
  assign w_own_req = (r_state == OWN_A) ? req_a : req_b;
  assign w_oth_req = (r_state == OWN_A) ? req_b : req_a;
  // rr_ptr: 0 favours A, 1 favours B when both request from idle
  assign w_win_b   = (req_a && req_b) ? r_rr_ptr : req_b;
  assign w_hold_p1 = {1'b0, r_hold_cnt} + (HW+1)'(1);
  assign w_hold_ok = w_hold_p1 >= (HW+1)'(MIN_FRAMES);
  assign w_hold_sat = w_hold_ok ? HW'(MIN_FRAMES) : w_hold_p1[HW-1:0];
  assign w_dig_nxt = (r_dig_idx == DW'(NUM_DIG - 1)) ?
                     '0 : r_dig_idx + DW'(1);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_scan_cnt    <= '0;
      r_dig_idx     <= '0;
      r_rr_ptr      <= 1'b0;
      r_hold_cnt    <= '0;
      r_snap        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en && (req_a || req_b)) begin
            r_state       <= w_win_b ? OWN_B : OWN_A;
            r_rr_ptr      <= ~w_win_b;
            r_snap        <= w_win_b ? pat_b : pat_a;
            r_scan_cnt    <= '0;
            r_dig_idx     <= '0;
            r_hold_cnt    <= '0;
            r_frame_start <= 1'b1;
          end
        end
        default: begin
          if (w_tick) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= w_dig_nxt;
          end else if (en) begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
          end
          if (w_fb) begin
            r_frame_start <= 1'b1;
            if (w_oth_req && (w_hold_ok || !w_own_req)) begin
              r_state    <= (r_state == OWN_A) ? OWN_B : OWN_A;
              r_rr_ptr   <= (r_state == OWN_B);
              r_hold_cnt <= '0;
              r_snap     <= (r_state == OWN_A) ? pat_b : pat_a;
            end else if (!w_own_req) begin
              r_state    <= IDLE;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= w_hold_sat;
              r_snap     <= (r_state == OWN_A) ? pat_a : pat_b;
            end
          end
        end
      endcase
    end
  end

`ifdef SEG_DISP_BLANK_EN
  localparam int BW = $clog2(BLANK_CYC + 1);
  logic [BW-1:0] r_blank_cnt;

  // Blank window runs alongside scan_cnt so the digit period is unchanged
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_blank_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_blank_cnt <= '0;
    end else if (w_tick) begin
      r_blank_cnt <= BW'(BLANK_CYC);
    end else if (r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - BW'(1);
    end
  end

  assign w_blank = (r_blank_cnt != '0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_onehot = {{(NUM_DIG-1){1'b0}}, 1'b1} << r_dig_idx;
  assign w_show   = en && (r_state != IDLE) && !w_blank;

  assign seg_sel     = w_show ? w_onehot : '0;
  assign seg_led     = w_show ? r_snap[{r_dig_idx, 3'b000} +: 8] : 8'h00;
  assign gnt_a       = (r_state == OWN_A);
  assign gnt_b       = (r_state == OWN_B);
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed + randomized bench for seg_disp_sched against a frame-level
// reference model (owner, cycle-in-frame, frames held).
module tb_seg_disp_sched;

  localparam int ND = 8;
  localparam int SD = 4;
  localparam int MF = 4;
  localparam int FR = ND * SD;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          en;
  logic          req_a;
  logic          req_b;
  logic [ND*8-1:0] pat_a;
  logic [ND*8-1:0] pat_b;
  logic          gnt_a;
  logic          gnt_b;
  logic [ND-1:0] seg_sel;
  logic [7:0]    seg_led;
  logic          frame_start;

  seg_disp_sched #(
    .NUM_DIG(ND), .SCAN_DIV(SD), .MIN_FRAMES(MF), .BLANK_CYC(2)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .en(en),
    .req_a(req_a), .pat_a(pat_a), .gnt_a(gnt_a),
    .req_b(req_b), .pat_b(pat_b), .gnt_b(gnt_b),
    .seg_sel(seg_sel), .seg_led(seg_led),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: owner 0=none 1=A 2=B; cyc = cycle position within frame
  int         m_own;
  int         m_cyc;
  int         m_held;
  int         m_rr;
  logic [7:0] m_snap [ND];
  logic       m_fs;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_own = 0; m_cyc = 0; m_held = 0; m_rr = 1; m_fs = 1'b0;
    for (int i = 0; i < ND; i++) m_snap[i] = 8'h00;
  endtask

  task automatic m_load(int who);
    for (int i = 0; i < ND; i++)
      m_snap[i] = (who == 1) ? pat_a[8*i +: 8] : pat_b[8*i +: 8];
  endtask

  task automatic m_edge();
    logic ra, rb, own_r, oth_r;
    int oth;
    ra = req_a; rb = req_b;
    m_fs = 1'b0;
    if (sys_rst) begin m_reset(); return; end
    if (!en) return;
    if (m_own == 0) begin
      if (ra || rb) begin
        m_own = (ra && rb) ? m_rr : (ra ? 1 : 2);
        m_rr = 3 - m_own;
        m_cyc = 0; m_held = 0; m_fs = 1'b1;
        m_load(m_own);
      end
    end else begin
      m_cyc++;
      if (m_cyc == FR) begin
        m_cyc = 0; m_fs = 1'b1;
        oth = 3 - m_own;
        own_r = (m_own == 1) ? ra : rb;
        oth_r = (m_own == 1) ? rb : ra;
        if (oth_r && (m_held + 1 >= MF || !own_r)) begin
          m_rr = m_own; m_own = oth; m_held = 0;
        end else if (!own_r) begin
          m_own = 0; m_held = 0;
        end else begin
          m_held = (m_held + 1 > MF) ? MF : m_held + 1;
        end
        if (m_own != 0) m_load(m_own);
      end
    end
  endtask

  task automatic chk_all();
    logic [ND-1:0] es;
    logic [7:0] el;
    es = (m_own != 0 && en) ? ND'(1) << (m_cyc / SD) : '0;
    el = (es != '0) ? m_snap[m_cyc / SD] : 8'h00;
    chk("gnt_a", 32'(gnt_a), 32'(m_own == 1));
    chk("gnt_b", 32'(gnt_b), 32'(m_own == 2));
    chk("seg_sel", 32'(seg_sel), 32'(es));
    chk("seg_led", 32'(seg_led), 32'(el));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk_all();
  endtask

  initial begin
    int cnt;
    sys_rst = 1'b1; en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    pat_a = '0; pat_b = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 sys_rst = 1'b0;
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_seg_sel", 32'(seg_sel), 0);

    // Idle with no requests
    repeat (100) step();

    // Single owner A, digit i = 0x10+i
    for (int i = 0; i < ND; i++) pat_a[8*i +: 8] = 8'(8'h10 + i);
    req_a = 1'b1;
    step();
    chk("t2_gnt", 32'(gnt_a), 1);
    chk("t2_fs", 32'(frame_start), 1);
    chk("t2_led0", 32'(seg_led), 32'h10);
    repeat (70) step();

    // Tear-free: change pattern mid-frame at digit 3
    for (int k = 0; k < 2*FR && seg_sel != 8'h08; k++) step();
    chk("t4_at_dig3", 32'(seg_sel), 32'h08);
    pat_a = {$urandom, $urandom};
    repeat (60) step();

    // Release with no competitor, then B requests
    req_a = 1'b0;
    for (int k = 0; k < 2*FR && gnt_a; k++) step();
    chk("t5_rel_gnt", 32'(gnt_a), 0);
    chk("t5_rel_sel", 32'(seg_sel), 0);
    repeat (3) step();
    pat_b = {$urandom, $urandom};
    req_b = 1'b1;
    step();
    chk("t5_gnt_b", 32'(gnt_b), 1);
    chk("t5_dig0", 32'(seg_sel), 1);

    // Asynchronous reset mid-frame at digit 5
    for (int k = 0; k < 2*FR && seg_sel != 8'h20; k++) step();
    chk("t6_at_dig5", 32'(seg_sel), 32'h20);
    #3 sys_rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'({gnt_a, gnt_b}), 0);
    chk("t6_rst_sel", 32'(seg_sel), 0);
    chk("t6_rst_led", 32'(seg_led), 0);
    m_reset();
    req_a = 1'b1; req_b = 1'b1;
    pat_a = {$urandom, $urandom};
    step();
    sys_rst = 1'b0;

    // Both requesting: A first, hands over after MIN_FRAMES frames
    step();
    chk("t3_gnt_a_first", 32'(gnt_a), 1);
    cnt = 0;
    for (int k = 0; k < 8*FR && !gnt_b; k++) begin
      if (gnt_a) cnt++;
      step();
    end
    chk("t3_a_cycles", 32'(cnt), 32'(MF*FR));
    chk("t3_swap_fs", 32'(frame_start), 1);
    chk("t3_swap_gnt_a", 32'(gnt_a), 0);
    cnt = 0;
    for (int k = 0; k < 8*FR && !gnt_a; k++) begin
      if (gnt_b) cnt++;
      step();
    end
    chk("t3_b_cycles", 32'(cnt), 32'(MF*FR));

    // Enable low freezes scan and arbitration
    repeat (13) step();
    en = 1'b0;
    repeat (50) step();
    chk("t6_en_sel", 32'(seg_sel), 0);
    en = 1'b1;
    repeat (100) step();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) req_a = ~req_a;
      if ($urandom_range(0, 39) == 0) req_b = ~req_b;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) pat_a = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pat_b = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
